// File: rtl/serial_mag_compare.sv
// serial_mag_compare
//   Sequential WIDTH-bit magnitude comparator. Latches two operands on an
//   accepted start, presents them one 2-bit slice per cycle (MSB slice first)
//   to an external 2-bit combinational comparator, and consumes its
//   lt/gt/eq flags in the same cycle. Stops at the first unequal slice and
//   reports a registered lt/gt/eq result together with a one-cycle done pulse.
//
//   Optional build macro: CMP_CHECK_EN
//     Adds the err output and a one-hot check on the comparator flags. A
//     malformed flag set ends the compare with err=1 and lt=gt=eq=0.
//     Without the macro, flags are resolved with gt > lt > eq priority and
//     an all-zero flag set counts as eq.

module serial_mag_compare #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             cmp_A1,
    output logic             cmp_A0,
    output logic             cmp_B1,
    output logic             cmp_B0,
    input  logic             cmp_lt,
    input  logic             cmp_gt,
    input  logic             cmp_eq,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             gt,
    output logic             eq
`ifdef CMP_CHECK_EN
   ,output logic             err
`endif
);

    // Number of 2-bit slices and the width of the slice index.
    localparam int K     = WIDTH / 2;
    localparam int IDX_W = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Registered state and outputs.
    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [WIDTH-1:0]   a_lat_q, a_lat_d;
    logic [WIDTH-1:0]   b_lat_q, b_lat_d;
    logic               lt_q,    lt_d;
    logic               gt_q,    gt_d;
    logic               eq_q,    eq_d;
    logic               done_q,  done_d;
    logic               busy_q,  busy_d;
`ifdef CMP_CHECK_EN
    logic               err_q,   err_d;
    logic               flags_onehot;
`endif

    // Slice currently under comparison, selected by idx.
    logic [1:0]         a_slice;
    logic [1:0]         b_slice;

    // Select the active 2-bit slice of each latched operand.
    always_comb begin
        a_slice = a_lat_q[2*int'(idx_q) +: 2];
        b_slice = b_lat_q[2*int'(idx_q) +: 2];
    end

    // Drive the comparator inputs only while scanning; zero otherwise.
    always_comb begin
        cmp_A1 = 1'b0;
        cmp_A0 = 1'b0;
        cmp_B1 = 1'b0;
        cmp_B0 = 1'b0;
        if (state_q == S_SCAN) begin
            cmp_A1 = a_slice[1];
            cmp_A0 = a_slice[0];
            cmp_B1 = b_slice[1];
            cmp_B0 = b_slice[0];
        end
    end

`ifdef CMP_CHECK_EN
    // Exactly one flag set: odd parity of the three, excluding all three set.
    always_comb begin
        flags_onehot = (cmp_lt ^ cmp_gt ^ cmp_eq) & ~(cmp_lt & cmp_gt & cmp_eq);
    end
`endif

    // Next-state and next-output computation for the compare sequencer.
    always_comb begin
        // NOTE: every _d gets a default first so no path leaves a variable
        // unassigned; a missing default here would infer a latch.
        state_d = state_q;
        idx_d   = idx_q;
        a_lat_d = a_lat_q;
        b_lat_d = b_lat_q;
        lt_d    = lt_q;
        gt_d    = gt_q;
        eq_d    = eq_q;
`ifdef CMP_CHECK_EN
        err_d   = err_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_lat_d = a;
                    b_lat_d = b;
                    idx_d   = IDX_W'(K - 1);
                    lt_d    = 1'b0;
                    gt_d    = 1'b0;
                    eq_d    = 1'b0;
`ifdef CMP_CHECK_EN
                    err_d   = 1'b0;
`endif
                    state_d = S_SCAN;
                end
            end

            S_SCAN: begin
`ifdef CMP_CHECK_EN
                if (!flags_onehot) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else
`endif
                if (cmp_gt) begin
                    gt_d    = 1'b1;
                    state_d = S_DONE;
                end else if (cmp_lt) begin
                    lt_d    = 1'b1;
                    state_d = S_DONE;
                end else if (idx_q == '0) begin
                    // Last slice equal (or no flag raised): operands are equal.
                    eq_d    = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q - 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs are registered copies of where the sequencer goes next.
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and output registers; asynchronous reset returns everything to idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_lat_q <= '0;
            b_lat_q <= '0;
            lt_q    <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef CMP_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values computed above, independent of statement order.
            state_q <= state_d;
            idx_q   <= idx_d;
            a_lat_q <= a_lat_d;
            b_lat_q <= b_lat_d;
            lt_q    <= lt_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
`ifdef CMP_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    // Output port assignments.
    assign busy = busy_q;
    assign done = done_q;
    assign lt   = lt_q;
    assign gt   = gt_q;
    assign eq   = eq_q;
`ifdef CMP_CHECK_EN
    assign err  = err_q;
`endif

endmodule

// File: tb/tb_serial_mag_compare.sv
// tb_serial_mag_compare
//   Directed bench for serial_mag_compare (WIDTH=8). Provides a behavioural
//   2-bit comparator that can be forced to return malformed flags.
//   Define CMP_CHECK_EN for both this file and the RTL to exercise err.

module tb_serial_mag_compare;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cmp_A1, cmp_A0, cmp_B1, cmp_B0;
    logic             cmp_lt, cmp_gt, cmp_eq;
    logic             busy, done, lt, gt, eq;
`ifdef CMP_CHECK_EN
    logic             err;
`endif

    // Comparator model mode: 0 = correct, 1 = lt=gt=1, 2 = all flags zero.
    int               cmp_mode;

    int               n_checks;
    int               n_passed;

    serial_mag_compare #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .cmp_A1 (cmp_A1),
        .cmp_A0 (cmp_A0),
        .cmp_B1 (cmp_B1),
        .cmp_B0 (cmp_B0),
        .cmp_lt (cmp_lt),
        .cmp_gt (cmp_gt),
        .cmp_eq (cmp_eq),
        .busy   (busy),
        .done   (done),
        .lt     (lt),
        .gt     (gt),
        .eq     (eq)
`ifdef CMP_CHECK_EN
       ,.err    (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 2-bit comparator, optionally corrupted.
    always_comb begin
        logic [1:0] sa, sb;
        sa = {cmp_A1, cmp_A0};
        sb = {cmp_B1, cmp_B0};
        cmp_lt = (sa < sb);
        cmp_gt = (sa > sb);
        cmp_eq = (sa == sb);
        if (cmp_mode == 1) begin
            cmp_lt = 1'b1;
            cmp_gt = 1'b1;
            cmp_eq = 1'b0;
        end else if (cmp_mode == 2) begin
            cmp_lt = 1'b0;
            cmp_gt = 1'b0;
            cmp_eq = 1'b0;
        end
    end

    // Generic comparison point.
    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    // Status vector {busy, done, lt, gt, eq}.
    task automatic check_status(input string tag, input logic [4:0] exp);
        check(tag, {3'b000, busy, done, lt, gt, eq}, {3'b000, exp});
    endtask

    // Slice vector {A1, A0, B1, B0}.
    task automatic check_slice(input string tag, input logic [3:0] exp);
        check(tag, {4'b0000, cmp_A1, cmp_A0, cmp_B1, cmp_B0}, {4'b0000, exp});
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_passed = 0;
        cmp_mode = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        a        = '0;
        b        = '0;

        // Reset state.
        repeat (2) next_cycle();
        check_status("reset_status", 5'b00000);
        check_slice("reset_slice", 4'b0000);
        rst_n = 1'b1;
        next_cycle();
        check_status("idle_status", 5'b00000);

        // C5 vs 35: first slice 11 vs 00 decides gt.
        a = 8'hC5; b = 8'h35; start = 1'b1;
        next_cycle();
        start = 1'b0; a = 8'h00; b = 8'hFF;
        check_slice("gt_c1_slice", 4'b1100);
        check_status("gt_c1_status", 5'b10000);
        next_cycle();
        check_status("gt_c2_done", 5'b11010);
        check_slice("gt_c2_slice", 4'b0000);
        next_cycle();
        check_status("gt_c3_idle", 5'b00010);

        // 5A vs 5A: all four slices scanned, eq.
        a = 8'h5A; b = 8'h5A; start = 1'b1;
        next_cycle();
        start = 1'b0;
        check_slice("eq_c1_slice", 4'b0101);
        check_status("eq_c1_status", 5'b10000);
        next_cycle();
        check_slice("eq_c2_slice", 4'b0101);
        next_cycle();
        check_slice("eq_c3_slice", 4'b1010);
        next_cycle();
        check_slice("eq_c4_slice", 4'b1010);
        check_status("eq_c4_status", 5'b10000);
        next_cycle();
        check_status("eq_c5_done", 5'b11001);
        next_cycle();
        check_status("eq_c6_idle", 5'b00001);

        // 12 vs 13 with start held high and operands changed mid-scan.
        a = 8'h12; b = 8'h13; start = 1'b1;
        next_cycle();
        a = 8'hFF; b = 8'h00;
        check_slice("lt_c1_slice", 4'b0000);
        check_status("lt_c1_status", 5'b10000);
        next_cycle();
        check_slice("lt_c2_slice", 4'b0101);
        next_cycle();
        check_slice("lt_c3_slice", 4'b0000);
        next_cycle();
        check_slice("lt_c4_slice", 4'b1011);
        next_cycle();
        check_status("lt_c5_done", 5'b11100);
        next_cycle();
        check_status("lt_c6_idle", 5'b00100);
        // start still high: accepted at this edge with FF vs 00.
        next_cycle();
        start = 1'b0;
        check_status("b2b_c1_cleared", 5'b10000);
        check_slice("b2b_c1_slice", 4'b1100);
        next_cycle();
        check_status("b2b_c2_done", 5'b11010);
        next_cycle();

        // Reset during cycle 2 of an a=b compare.
        a = 8'h5A; b = 8'h5A; start = 1'b1;
        next_cycle();
        start = 1'b0;
        next_cycle();
        check_slice("rst_c2_slice", 4'b0101);
        rst_n = 1'b0;
        #1;
        check_status("rst_abort_status", 5'b00000);
        check_slice("rst_abort_slice", 4'b0000);
        next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            check_status("rst_no_done", 5'b00000);
        end

`ifdef CMP_CHECK_EN
        // Malformed flags (lt=gt=1) end the compare with err.
        a = 8'h12; b = 8'h13; start = 1'b1;
        next_cycle();
        start = 1'b0;
        cmp_mode = 1;
        check(("chk_c1_err"), {7'd0, err}, 8'd0);
        next_cycle();
        cmp_mode = 0;
        check_status("chk_c2_done", 5'b11000);
        check("chk_c2_err", {7'd0, err}, 8'd1);
        next_cycle();
        check("chk_c3_err_hold", {7'd0, err}, 8'd1);
        // Next start clears err; normal lt result follows.
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        check("chk_clear_err", {7'd0, err}, 8'd0);
        repeat (3) next_cycle();
        next_cycle();
        check_status("chk_lt_done", 5'b11100);
        check("chk_lt_err", {7'd0, err}, 8'd0);
        next_cycle();
`else
        // lt=gt=1 resolves to gt by priority.
        a = 8'h00; b = 8'h00; start = 1'b1;
        next_cycle();
        start = 1'b0;
        cmp_mode = 1;
        check_slice("prio_c1_slice", 4'b0000);
        next_cycle();
        cmp_mode = 0;
        check_status("prio_gt_done", 5'b11010);
        next_cycle();
        // All-zero flags count as eq and keep scanning to the last slice.
        a = 8'h33; b = 8'hCC; start = 1'b1;
        next_cycle();
        start = 1'b0;
        cmp_mode = 2;
        check_slice("zero_c1_slice", 4'b0011);
        repeat (3) next_cycle();
        check_status("zero_c4_status", 5'b10000);
        next_cycle();
        cmp_mode = 0;
        check_status("zero_c5_done", 5'b11001);
        next_cycle();
`endif

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_mag_compare.md
# serial_mag_compare

Sequential multi-bit magnitude comparator built around the team's 2-bit combinational comparator. Latches two WIDTH-bit operands on a start request, drives them to the 2-bit comparator one 2-bit slice per cycle, MSB slice first, and consumes its lt/gt/eq flags. Terminates early on the first unequal slice. Reports a registered lt/gt/eq result with a one-cycle done pulse.

## Interface
- WIDTH, 8, operand width in bits; even, >= 2; slice count K = WIDTH/2
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; accepted only when busy=0
- a  in  WIDTH  operand A, sampled on accept
- b  in  WIDTH  operand B, sampled on accept
- cmp_A1, cmp_A0  out  1 each  current A slice to the 2-bit comparator (A1 = slice MSB)
- cmp_B1, cmp_B0  out  1 each  current B slice to the 2-bit comparator
- cmp_lt, cmp_gt, cmp_eq  in  1 each  combinational flags returned by the 2-bit comparator, same cycle
- busy  out  1  high in SCAN and DONE
- done  out  1  one-cycle pulse, result valid
- lt, gt, eq  out  1 each  registered result, A relative to B
- err  out  1  only with CMP_CHECK_EN

## Operation
- States: IDLE, SCAN, DONE.
- IDLE: busy=0, slice outputs 0. On start=1, latch a and b, set idx=K-1, clear lt/gt/eq (and err), go to SCAN.
- SCAN: drive cmp_A1/A0 = A_lat[2*idx+1:2*idx] and cmp_B1/B0 = B_lat[2*idx+1:2*idx] combinationally from state and idx. Sample the flags at the clock edge:
  - cmp_gt=1: gt<=1, go to DONE.
  - else cmp_lt=1: lt<=1, go to DONE.
  - else cmp_eq=1 and idx==0: eq<=1, go to DONE.
  - else cmp_eq=1: idx<=idx-1, stay in SCAN.
- Flag priority without the check option: gt > lt > eq. All flags 0 is treated as eq.
- DONE: done=1 for exactly one cycle, busy=1, slice outputs 0. Unconditionally go to IDLE.
- lt/gt/eq hold their value through IDLE until the next accepted start clears them. Exactly one of them is 1 after any completed compare.
- start while busy=1 is ignored and not queued.
- idx width is clog2(K), minimum 1. It never wraps: SCAN exits at idx==0.

## Timing
- Reset (async assert, sync release): state=IDLE, idx=0, latched operands=0, lt=gt=eq=0, done=0, busy=0, slice outputs=0, err=0.
- Reset mid-SCAN aborts immediately. No done pulse is produced.
- start accepted at edge E0. SCAN occupies cycles 1..n, where n = number of slices examined (1..K). done is high in cycle n+1. IDLE is reached at cycle n+2, and start is accepted again at that edge.
- Latency from accept to done: best case 2 cycles, worst case K+1 cycles. Back-to-back throughput is one compare per n+2 cycles.
- a and b may change freely after the accept edge.
- The combinational path through the 2-bit comparator lands in this block's state/result registers within one cycle.

## Configuration
- CMP_CHECK_EN defined:
  - adds the err output.
  - In SCAN, if {cmp_lt,cmp_gt,cmp_eq} is not one-hot, err<=1, lt=gt=eq stay 0, and the block goes to DONE (done still pulses).
  - err is cleared on the next accepted start.
- CMP_CHECK_EN undefined:
  - no err port, no check logic.
  - The gt > lt > eq priority above applies.

## Test plan
- WIDTH=8, a=0xC5, b=0x35, start at E0 -> slice outputs A=11, B=00 in cycle 1; done and gt=1 in cycle 2; lt=eq=0.
- a=b=0x5A -> SCAN cycles 1-4 with slices 01,01,10,10 on both sides; done and eq=1 in cycle 5.
- a=0x12, b=0x13 -> first three slices equal, last slice A=10 vs B=11; done and lt=1 in cycle 5.
- start held high through SCAN with new operands -> ignored; the first result is unchanged. start in the cycle after done -> accepted, and lt/gt/eq clear at that edge.
- rst_n low during cycle 2 of an a=b compare -> busy, done, lt, gt, eq and slice outputs go to 0 immediately. No done pulse after release.
- CMP_CHECK_EN, comparator model forced to lt=gt=1 in cycle 1 -> err=1 and done in cycle 2, lt=gt=eq=0. err clears on the next start.
